fb_mem_arbiter: RTL and testbench

//  Shares the single framebuffer memory master port between the VGA renderer's

---
 rtl/fb_mem_arbiter_if.sv | 41 ++++
 rtl/fb_mem_arbiter.sv | 99 +++++++++
 tb/tb_fb_mem_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_mem_arbiter_if.sv
// Avalon-MM bundle between the arbiter and its display, sim and memory ports.
// slave is the arbiter's view; master is the surrounding environment's view.
interface fb_mem_arbiter_if #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] disp_address;
    logic              disp_read;
    logic              disp_waitrequest;
    logic [DATA_W-1:0] disp_readdata;
    logic [ADDR_W-1:0] sim_address;
    logic              sim_read;
    logic              sim_write;
    logic [DATA_W-1:0] sim_writedata;
    logic              sim_waitrequest;
    logic [DATA_W-1:0] sim_readdata;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_waitrequest;
    logic [DATA_W-1:0] mem_readdata;

    modport slave (
        input  disp_address, disp_read,
        input  sim_address, sim_read, sim_write, sim_writedata,
        input  mem_waitrequest, mem_readdata,
        output disp_waitrequest, disp_readdata,
        output sim_waitrequest, sim_readdata,
        output mem_address, mem_read, mem_write, mem_writedata
    );

    modport master (
        output disp_address, disp_read,
        output sim_address, sim_read, sim_write, sim_writedata,
        output mem_waitrequest, mem_readdata,
        input  disp_waitrequest, disp_readdata,
        input  sim_waitrequest, sim_readdata,
        input  mem_address, mem_read, mem_write, mem_writedata
    );
endinterface

// File: rtl/fb_mem_arbiter.sv
// Framebuffer memory arbiter: display fetch has priority, the sim engine
// is guaranteed a slot once it has waited STARVE_LIMIT cycles.
module fb_mem_arbiter #(
    parameter int ADDR_W       = 23,
    parameter int DATA_W       = 8,
    parameter int STARVE_LIMIT = 16
) (
    input  logic            clk,
    input  logic            reset,
    fb_mem_arbiter_if.slave bus,
    output logic            grant_sim
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT_DISP = 2'd1,
        GRANT_SIM  = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CW-1:0]     starve_cnt;
    logic              sim_req;
    logic              starve_full;
    logic [ADDR_W-1:0] m_addr;
    logic              m_rd;
    logic              m_wr;
    logic [DATA_W-1:0] m_wd;
    logic              d_wait;
    logic              s_wait;

    assign sim_req     = bus.sim_read | bus.sim_write;
    assign starve_full = (starve_cnt == CW'(STARVE_LIMIT));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Sim wait counter: counts pending sim cycles, cleared on sim grant.
    always_ff @(posedge clk) begin
        if (reset)
            starve_cnt <= '0;
        else if (state == IDLE && next_state == GRANT_SIM)
            starve_cnt <= '0;
        else if (sim_req && state != GRANT_SIM && !starve_full)
            starve_cnt <= starve_cnt + 1'b1;
    end

    // Next state and bus mux; reset idles everything combinationally.
    always_comb begin
        next_state = state;
        m_addr     = '0;
        m_rd       = 1'b0;
        m_wr       = 1'b0;
        m_wd       = '0;
        d_wait     = 1'b1;
        s_wait     = 1'b1;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (sim_req && (starve_full || !bus.disp_read))
                        next_state = GRANT_SIM;
                    else if (bus.disp_read)
                        next_state = GRANT_DISP;
                end
                GRANT_DISP: begin
                    m_addr = bus.disp_address;
                    m_rd   = bus.disp_read;
                    d_wait = bus.mem_waitrequest;
                    if (!bus.disp_read || !bus.mem_waitrequest)
                        next_state = IDLE;
                end
                GRANT_SIM: begin
                    m_addr = bus.sim_address;
                    m_rd   = bus.sim_read;
                    m_wr   = bus.sim_write & ~bus.sim_read;
                    m_wd   = bus.sim_writedata;
                    s_wait = bus.mem_waitrequest;
                    if (!sim_req || !bus.mem_waitrequest)
                        next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    assign bus.mem_address      = m_addr;
    assign bus.mem_read         = m_rd;
    assign bus.mem_write        = m_wr;
    assign bus.mem_writedata    = m_wd;
    assign bus.disp_waitrequest = d_wait;
    assign bus.sim_waitrequest  = s_wait;
    assign bus.disp_readdata    = bus.mem_readdata;
    assign bus.sim_readdata     = bus.mem_readdata;
    assign grant_sim            = (state == GRANT_SIM);
endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter with STARVE_LIMIT=4.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_fb_mem_arbiter;
    localparam int AW = 23;
    localparam int DW = 8;

    logic clk;
    logic reset;
    logic grant_sim;
    int   total;
    int   bad;

    fb_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    fb_mem_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .STARVE_LIMIT(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave),
        .grant_sim(grant_sim)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_inputs();
        bus.disp_address    = '0;
        bus.disp_read       = 1'b0;
        bus.sim_address     = '0;
        bus.sim_read        = 1'b0;
        bus.sim_write       = 1'b0;
        bus.sim_writedata   = '0;
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata    = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        bus.disp_read    = 1'b1;
        bus.disp_address = 23'h000010;
        bus.sim_write    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            total++;
            if ({bus.mem_read, bus.mem_write} !== 2'b00) begin
                bad++;
                $display("FAIL rst_cmd got=%b want=00",
                         {bus.mem_read, bus.mem_write});
            end
            total++;
            if ({bus.disp_waitrequest, bus.sim_waitrequest} !== 2'b11) begin
                bad++;
                $display("FAIL rst_wait got=%b want=11",
                         {bus.disp_waitrequest, bus.sim_waitrequest});
            end
        end
        reset = 1'b0;
        #1;
        total++;
        if (bus.mem_read !== 1'b0) begin
            bad++;
            $display("FAIL rst_rel_idle got=%b want=0", bus.mem_read);
        end
        @(negedge clk);
        #1;
        total++;
        if ({bus.mem_read, bus.mem_write} !== 2'b10) begin
            bad++;
            $display("FAIL rst_first_cmd got=%b want=10",
                     {bus.mem_read, bus.mem_write});
        end
        total++;
        if (bus.mem_address !== 23'h000010) begin
            bad++;
            $display("FAIL rst_first_addr got=%h want=000010",
                     bus.mem_address);
        end
    endtask

    task automatic test_disp_read();
        do_reset();
        bus.disp_address    = 23'h000100;
        bus.disp_read       = 1'b1;
        bus.mem_waitrequest = 1'b1;
        #1;
        total++;
        if (bus.disp_waitrequest !== 1'b1) begin
            bad++;
            $display("FAIL dr_idle_wait got=%b want=1", bus.disp_waitrequest);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            total++;
            if ({bus.mem_read, bus.disp_waitrequest} !== 2'b11) begin
                bad++;
                $display("FAIL dr_stall%0d got=%b want=11", i,
                         {bus.mem_read, bus.disp_waitrequest});
            end
            total++;
            if (bus.mem_address !== 23'h000100) begin
                bad++;
                $display("FAIL dr_addr%0d got=%h want=000100", i,
                         bus.mem_address);
            end
        end
        @(negedge clk);
        bus.mem_waitrequest = 1'b0;
        bus.mem_readdata    = 8'hAB;
        #1;
        total++;
        if (bus.disp_waitrequest !== 1'b0) begin
            bad++;
            $display("FAIL dr_done_wait got=%b want=0", bus.disp_waitrequest);
        end
        total++;
        if (bus.disp_readdata !== 8'hAB) begin
            bad++;
            $display("FAIL dr_data got=%h want=ab", bus.disp_readdata);
        end
        total++;
        if (bus.sim_waitrequest !== 1'b1) begin
            bad++;
            $display("FAIL dr_sim_wait got=%b want=1", bus.sim_waitrequest);
        end
        @(negedge clk);
        #1;
        total++;
        if ({bus.mem_read, bus.disp_waitrequest} !== 2'b01) begin
            bad++;
            $display("FAIL dr_after got=%b want=01",
                     {bus.mem_read, bus.disp_waitrequest});
        end
        bus.disp_read = 1'b0;
    endtask

    task automatic test_priority();
        do_reset();
        bus.disp_address = 23'h000200;
        bus.sim_address  = 23'h000300;
        bus.disp_read    = 1'b1;
        bus.sim_read     = 1'b1;
        bus.mem_readdata = 8'h11;
        @(negedge clk);
        #1;
        total++;
        if (bus.mem_address !== 23'h000200 || grant_sim !== 1'b0) begin
            bad++;
            $display("FAIL pr_disp_first addr=%h gs=%b want 000200 0",
                     bus.mem_address, grant_sim);
        end
        total++;
        if ({bus.disp_waitrequest, bus.sim_waitrequest} !== 2'b01) begin
            bad++;
            $display("FAIL pr_waits got=%b want=01",
                     {bus.disp_waitrequest, bus.sim_waitrequest});
        end
        bus.disp_read = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if ({bus.mem_read, bus.sim_waitrequest} !== 2'b01) begin
            bad++;
            $display("FAIL pr_gap got=%b want=01",
                     {bus.mem_read, bus.sim_waitrequest});
        end
        @(negedge clk);
        #1;
        total++;
        if (grant_sim !== 1'b1 || bus.mem_address !== 23'h000300) begin
            bad++;
            $display("FAIL pr_sim_next gs=%b addr=%h want 1 000300",
                     grant_sim, bus.mem_address);
        end
        total++;
        if (bus.sim_waitrequest !== 1'b0 || bus.sim_readdata !== 8'h11) begin
            bad++;
            $display("FAIL pr_sim_done w=%b d=%h want 0 11",
                     bus.sim_waitrequest, bus.sim_readdata);
        end
        bus.sim_read = 1'b0;
        @(negedge clk);
        #1;
        total++;
        if (grant_sim !== 1'b0) begin
            bad++;
            $display("FAIL pr_release got=%b want=0", grant_sim);
        end
    endtask

    task automatic test_starvation();
        logic exp_gs [8];
        logic exp_rd [8];
        int   exp_cnt [8];
        exp_gs  = '{0, 0, 0, 0, 0, 1, 0, 0};
        exp_rd  = '{0, 1, 0, 1, 0, 1, 0, 1};
        exp_cnt = '{0, 1, 2, 3, 4, 0, 0, 1};
        do_reset();
        bus.disp_address = 23'h000400;
        bus.sim_address  = 23'h000500;
        bus.disp_read    = 1'b1;
        bus.sim_read     = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            total++;
            if (grant_sim !== exp_gs[c] || bus.mem_read !== exp_rd[c]) begin
                bad++;
                $display("FAIL sv_cyc%0d gs=%b rd=%b want %b %b", c,
                         grant_sim, bus.mem_read, exp_gs[c], exp_rd[c]);
            end
            total++;
            if (int'(dut.starve_cnt) !== exp_cnt[c]) begin
                bad++;
                $display("FAIL sv_cnt%0d got=%0d want=%0d", c,
                         dut.starve_cnt, exp_cnt[c]);
            end
        end
        bus.disp_read = 1'b0;
        bus.sim_read  = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        bus.disp_read       = 1'b1;
        bus.sim_write       = 1'b1;
        bus.mem_waitrequest = 1'b1;
        repeat (7) @(negedge clk);
        #1;
        total++;
        if (int'(dut.starve_cnt) !== 4 || bus.mem_read !== 1'b1) begin
            bad++;
            $display("FAIL sat_cnt cnt=%0d rd=%b want 4 1",
                     dut.starve_cnt, bus.mem_read);
        end
        bus.mem_waitrequest = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if (grant_sim !== 1'b1 || bus.mem_write !== 1'b1) begin
            bad++;
            $display("FAIL sat_sim_wins gs=%b wr=%b want 1 1",
                     grant_sim, bus.mem_write);
        end
        bus.disp_read = 1'b0;
        bus.sim_write = 1'b0;
    endtask

    task automatic test_sim_write_max();
        do_reset();
        bus.sim_address   = 23'h7FFFFF;
        bus.sim_writedata = 8'h5A;
        bus.sim_write     = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if ({bus.mem_read, bus.mem_write} !== 2'b01) begin
            bad++;
            $display("FAIL sw_cmd got=%b want=01",
                     {bus.mem_read, bus.mem_write});
        end
        total++;
        if (bus.mem_address !== 23'h7FFFFF || bus.mem_writedata !== 8'h5A) begin
            bad++;
            $display("FAIL sw_bus addr=%h data=%h want 7fffff 5a",
                     bus.mem_address, bus.mem_writedata);
        end
        total++;
        if ({bus.disp_waitrequest, bus.sim_waitrequest} !== 2'b10) begin
            bad++;
            $display("FAIL sw_waits got=%b want=10",
                     {bus.disp_waitrequest, bus.sim_waitrequest});
        end
        bus.sim_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if ({bus.mem_read, bus.mem_write} !== 2'b10) begin
            bad++;
            $display("FAIL sw_rd_wins got=%b want=10",
                     {bus.mem_read, bus.mem_write});
        end
        bus.sim_read  = 1'b0;
        bus.sim_write = 1'b0;
    endtask

    task automatic test_reset_midxfer();
        do_reset();
        bus.sim_address     = 23'h000042;
        bus.sim_write       = 1'b1;
        bus.mem_waitrequest = 1'b1;
        @(negedge clk);
        #1;
        total++;
        if (bus.mem_write !== 1'b1 || bus.sim_waitrequest !== 1'b1) begin
            bad++;
            $display("FAIL rm_busy wr=%b w=%b want 1 1",
                     bus.mem_write, bus.sim_waitrequest);
        end
        reset = 1'b1;
        #1;
        total++;
        if (bus.mem_write !== 1'b0 || bus.sim_waitrequest !== 1'b1) begin
            bad++;
            $display("FAIL rm_abort wr=%b w=%b want 0 1",
                     bus.mem_write, bus.sim_waitrequest);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if (grant_sim !== 1'b0 || bus.mem_write !== 1'b0
            || bus.sim_waitrequest !== 1'b1) begin
            bad++;
            $display("FAIL rm_idle gs=%b wr=%b w=%b want 0 0 1",
                     grant_sim, bus.mem_write, bus.sim_waitrequest);
        end
        bus.sim_write = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_disp_read();
        test_priority();
        test_starvation();
        test_saturate();
        test_sim_write_max();
        test_reset_midxfer();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
